// File: rtl/cct_transform_pipe.sv
// Two-stage classify/transform pipeline: S1 captures word and class,
// S2 holds the transformed result; saturating popcount accumulator.
module cct_transform_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             sync_clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] cct_input,
    input  logic             acc_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] cct_output,
    output logic [1:0]       out_class,
    output logic [CNT_W-1:0] word_count
);
    localparam int HW = WIDTH / 2;

    typedef enum logic [1:0] {
        CL_PASS   = 2'd0,
        CL_INVERT = 2'd1,
        CL_POP    = 2'd2,
        CL_ACCUM  = 2'd3
    } class_e;

    logic             s1_vld_q, s1_vld_d;
    logic [WIDTH-1:0] s1_data_q, s1_data_d;
    class_e           s1_cls_q, s1_cls_d;
    logic             s2_vld_q, s2_vld_d;
    logic [WIDTH-1:0] s2_data_q, s2_data_d;
    class_e           s2_cls_q, s2_cls_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             adv;
    logic             accept;
    class_e           in_cls;
    logic [WIDTH-1:0] pop;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] acc_sat;
    logic [WIDTH-1:0] res;

    function automatic logic [WIDTH-1:0] popcnt(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + WIDTH'(v[i]);
        end
        return n;
    endfunction

    assign adv      = !s2_vld_q || out_ready;
    assign in_ready = adv && !sync_clear && clear_n;
    assign accept   = in_valid && in_ready;

    // ACCUM is folded into the S1 class so acc_en need not be stored
    always_comb begin
        in_cls = CL_PASS;
        if (cct_input[WIDTH-1 -: HW] == HW'(3)) begin
            in_cls = CL_INVERT;
        end else if (cct_input[WIDTH-1]) begin
            in_cls = acc_en ? CL_ACCUM : CL_POP;
        end
    end

    assign pop     = popcnt(s1_data_q);
    assign sum     = {1'b0, acc_q} + {1'b0, pop};
    assign acc_sat = sum[WIDTH] ? '1 : sum[WIDTH-1:0];

    always_comb begin
        res = s1_data_q;
        unique case (s1_cls_q)
            CL_INVERT: res = ~s1_data_q;
            CL_POP:    res = pop;
            CL_ACCUM:  res = acc_sat;
            default:   res = s1_data_q;
        endcase
    end

    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_data_d = s1_data_q;
        s1_cls_d  = s1_cls_q;
        s2_vld_d  = s2_vld_q;
        s2_data_d = s2_data_q;
        s2_cls_d  = s2_cls_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        if (sync_clear) begin
            s1_vld_d  = 1'b0;
            s1_data_d = '0;
            s1_cls_d  = CL_PASS;
            s2_vld_d  = 1'b0;
            s2_data_d = '0;
            s2_cls_d  = CL_PASS;
            acc_d     = '0;
            cnt_d     = '0;
        end else begin
            if (s2_vld_q && out_ready) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            // An empty S1 moving forward leaves a zeroed output word
            if (adv) begin
                s2_vld_d  = s1_vld_q;
                s2_data_d = s1_vld_q ? res : '0;
                s2_cls_d  = s1_vld_q ? s1_cls_q : CL_PASS;
                if (s1_vld_q && s1_cls_q == CL_ACCUM) begin
                    acc_d = acc_sat;
                end
                s1_vld_d  = accept;
                s1_data_d = accept ? cct_input : '0;
                s1_cls_d  = accept ? in_cls : CL_PASS;
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
            s1_cls_q  <= CL_PASS;
            s2_vld_q  <= 1'b0;
            s2_data_q <= '0;
            s2_cls_q  <= CL_PASS;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_data_q <= s1_data_d;
            s1_cls_q  <= s1_cls_d;
            s2_vld_q  <= s2_vld_d;
            s2_data_q <= s2_data_d;
            s2_cls_q  <= s2_cls_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid  = s2_vld_q;
    assign cct_output = s2_data_q;
    assign out_class  = s2_cls_q;
    assign word_count = cnt_q;

endmodule

// File: tb/tb_cct_transform_pipe.sv
// Scoreboard bench for cct_transform_pipe: directed cases, random
// traffic with backpressure/flushes, and a word_count wrap run.
module tb_cct_transform_pipe;
    localparam int W  = 8;
    localparam int CW = 16;

    logic          clk;
    logic          clear_n;
    logic          sync_clear;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  cct_input;
    logic          acc_en;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  cct_output;
    logic [1:0]    out_class;
    logic [CW-1:0] word_count;

    cct_transform_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .sync_clear (sync_clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cct_input  (cct_input),
        .acc_en     (acc_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .cct_output (cct_output),
        .out_class  (out_class),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] cls;
    } exp_t;

    exp_t        sbq[$];
    logic [7:0]  m_acc;
    logic [15:0] mon_count;
    int          n_tests;
    int          n_fail;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t",
                     nm, got, exp, $time);
        end
    endtask

    // Reference model: classification and transform by plain arithmetic
    function automatic exp_t model(input logic [7:0] w, input logic ae);
        exp_t e;
        int   s;
        if ((w >> 4) == 3) begin
            e.data = ~w;
            e.cls  = 2'd1;
        end else if (w >= 8'h80) begin
            if (ae) begin
                s = int'(m_acc) + $countones(w);
                if (s > 255) s = 255;
                m_acc  = 8'(s);
                e.data = 8'(s);
                e.cls  = 2'd3;
            end else begin
                e.data = 8'($countones(w));
                e.cls  = 2'd2;
            end
        end else begin
            e.data = w;
            e.cls  = 2'd0;
        end
        return e;
    endfunction

    // Tracker: words seen accepted are pushed just before their edge
    initial forever begin
        @(negedge clk);
        #1;
        if (clear_n) begin
            if (sync_clear) begin
                sbq.delete();
                m_acc     = 8'h00;
                mon_count = 16'h0000;
            end else if (in_valid && in_ready) begin
                sbq.push_back(model(cct_input, acc_en));
            end
        end
    end

    // Monitor: compares presented output against the queue head
    initial forever begin
        @(negedge clk);
        if (clear_n) begin
            chk("word_count", word_count, mon_count);
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %0h, required none",
                             cct_output);
                end else begin
                    chk("out_data", cct_output, sbq[0].data);
                    chk("out_class", out_class, sbq[0].cls);
                    if (out_ready && !sync_clear) begin
                        void'(sbq.pop_front());
                        mon_count = mon_count + 16'd1;
                    end
                end
            end else begin
                chk("idle_data", cct_output, 0);
                chk("idle_class", out_class, 0);
            end
        end
    end

    task automatic send(input logic [7:0] w, input logic ae);
        bit ok;
        ok        = 1'b0;
        in_valid  = 1'b1;
        cct_input = w;
        acc_en    = ae;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready 0, required 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            #2;
            if (sbq.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending, required 0",
                     sbq.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string nm, input logic [7:0] d,
                              input logic [1:0] c);
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_data"}, cct_output, d);
        chk({nm, "_class"}, out_class, c);
    endtask

    initial begin
        bit         found;
        logic [7:0] w;
        n_tests    = 0;
        n_fail     = 0;
        m_acc      = 8'h00;
        mon_count  = 16'h0000;
        clear_n    = 1'b0;
        sync_clear = 1'b0;
        in_valid   = 1'b0;
        cct_input  = 8'h00;
        acc_en     = 1'b0;
        out_ready  = 1'b1;

        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_data", cct_output, 0);
        chk("rst_class", out_class, 0);
        chk("rst_count", word_count, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        clear_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Back-to-back classes and two-register latency
        send(8'h35, 1'b0);
        chk("lat_early", out_valid, 0);
        send(8'h81, 1'b0);
        expect_now("t31_inv", 8'hCA, 2'd1);
        send(8'h12, 1'b0);
        expect_now("t31_pop", 8'h02, 2'd2);
        idle(1);
        expect_now("t31_pass", 8'h12, 2'd0);
        idle(3);

        // Accumulation, hold across PASS
        send(8'hFF, 1'b1);
        send(8'hFF, 1'b1);
        expect_now("t32_a1", 8'h08, 2'd3);
        send(8'h81, 1'b1);
        expect_now("t32_a2", 8'h10, 2'd3);
        send(8'h40, 1'b0);
        expect_now("t32_a3", 8'h12, 2'd3);
        send(8'h80, 1'b1);
        expect_now("t32_pass", 8'h40, 2'd0);
        idle(1);
        expect_now("t32_hold", 8'h13, 2'd3);
        idle(2);

        // Saturation: 0x13 + 29*8 + 1 = 0xFC, then saturate
        for (int i = 0; i < 29; i++) send(8'hFF, 1'b1);
        send(8'h80, 1'b1);
        send(8'hFF, 1'b1);
        expect_now("t33_fc", 8'hFC, 2'd3);
        send(8'h80, 1'b1);
        expect_now("t33_sat1", 8'hFF, 2'd3);
        idle(1);
        expect_now("t33_sat2", 8'hFF, 2'd3);
        drain();

        // Synchronous flush with two words in flight
        send(8'hFF, 1'b1);
        send(8'hFF, 1'b1);
        sync_clear = 1'b1;
        @(posedge clk);
        #1;
        sync_clear = 1'b0;
        chk("t35_valid", out_valid, 0);
        chk("t35_count", word_count, 0);
        chk("t35_data", cct_output, 0);
        send(8'hFF, 1'b1);
        idle(1);
        expect_now("t35_acc0", 8'h08, 2'd3);
        drain();

        // Backpressure: six words, five stalled cycles
        sync_clear = 1'b1;
        idle(1);
        sync_clear = 1'b0;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        out_ready = 1'b0;
        fork
            begin
                send(8'h03, 1'b0);
                send(8'h04, 1'b0);
                send(8'h05, 1'b0);
                send(8'h06, 1'b0);
            end
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("t34_in_ready", in_ready, 0);
                    chk("t34_valid", out_valid, 1);
                    chk("t34_frozen", cct_output, 8'h01);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("t34_count", word_count, 6);

        // Asynchronous reset between edges mid-stream
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        #1;
        clear_n = 1'b0;
        #1;
        chk("t36_valid", out_valid, 0);
        chk("t36_in_ready", in_ready, 0);
        chk("t36_data", cct_output, 0);
        chk("t36_class", out_class, 0);
        chk("t36_count", word_count, 0);
        sbq.delete();
        m_acc     = 8'h00;
        mon_count = 16'h0000;
        #1;
        clear_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'h35, 1'b0);
        chk("t36_lat", out_valid, 0);
        idle(1);
        expect_now("t36_inv", 8'hCA, 2'd1);
        drain();

        // Random traffic with backpressure and occasional flushes
        for (int i = 0; i < 3000; i++) begin
            w = 8'($urandom);
            if ($urandom_range(2, 0) == 0) w[7:4] = 4'h3;
            in_valid   = ($urandom_range(3, 0) != 0);
            cct_input  = w;
            acc_en     = 1'($urandom);
            out_ready  = ($urandom_range(3, 0) != 0);
            sync_clear = ($urandom_range(63, 0) == 0);
            @(posedge clk);
            #1;
        end
        sync_clear = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        drain();

        // Continuous stream until word_count wraps
        found    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            cct_input = 8'($urandom);
            acc_en    = 1'($urandom);
            @(posedge clk);
            #1;
            if (mon_count == 16'hFFFF && out_valid) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_tests++;
            n_fail++;
            $display("FAIL wrap_timeout: got count %0h, required ffff",
                     mon_count);
        end else begin
            chk("wrap_pre", word_count, 16'hFFFF);
            @(posedge clk);
            #1;
            chk("wrap_zero", word_count, 0);
        end
        in_valid = 1'b0;
        drain();
        chk("final_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cct_transform_pipe.md
CCT_TRANSFORM_PIPE -- requirements
Module: cct_transform_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data width; SHALL be even and >= 4.
REQ-002 Parameter CNT_W, default 16, width of word_count.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 clear_n  input  1  reset, asynchronous, active-low.
REQ-005 sync_clear  input  1  synchronous flush, active-high.
REQ-006 in_valid  input  1  cct_input holds a valid word.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 cct_input  input  WIDTH  input word.
REQ-009 acc_en  input  1  accumulate-popcount mode, sampled with each accepted word.
REQ-010 out_valid  output  1  cct_output/out_class valid.
REQ-011 out_ready  input  1  consumer accepts output.
REQ-012 cct_output  output  WIDTH  transformed word.
REQ-013 out_class  output  2  0=PASS, 1=INVERT, 2=POP, 3=ACCUM.
REQ-014 word_count  output  CNT_W  count of completed output handshakes.

Function
REQ-015 Word SHALL be accepted on a rising edge when in_valid && in_ready.
REQ-016 Classification priority: upper WIDTH/2 bits == 3 -> INVERT; else cct_input[WIDTH-1]==1 -> POP (ACCUM if acc_en); else PASS.
REQ-017 INVERT SHALL output ~cct_input; PASS SHALL output cct_input unchanged.
REQ-018 POP SHALL output number of set bits in cct_input, zero-extended to WIDTH.
REQ-019 ACCUM SHALL output acc + popcount, saturating at 2^WIDTH-1, and SHALL load that value into the WIDTH-bit register acc.
REQ-020 acc SHALL update only when the ACCUM word loads stage 2, never during stall; acc SHALL hold across PASS/INVERT/POP words.
REQ-021 Pipeline: two register stages S1 (capture word, class, acc_en) and S2 (result, class); each with valid bit.
REQ-022 adv = !out_valid || out_ready; when adv, S1->S2 and input->S1 on the same edge.
REQ-023 in_ready = adv && !sync_clear && clear_n; throughput one word per cycle with out_ready held 1.
REQ-024 Latency: word accepted at edge k SHALL present out_valid=1 after edge k+1 (visible in cycle following edge k+1, i.e., two-register path) absent stall.
REQ-025 While out_valid && !out_ready, cct_output and out_class SHALL hold stable; no word SHALL be dropped or duplicated.
REQ-026 word_count SHALL increment by 1 on each out_valid && out_ready edge, wrapping from 2^CNT_W-1 to 0.
REQ-027 sync_clear=1 at an edge SHALL invalidate S1 and S2, zero acc, word_count, cct_output, out_class; overrides simultaneous input accept and output handshake (that handshake not counted).
REQ-028 Output word with out_valid=0 SHALL read as 0.

Reset
REQ-029 clear_n low SHALL immediately force out_valid=0, in_ready=0, cct_output=0, out_class=0, word_count=0, acc=0, S1/S2 valid=0, independent of clk.
REQ-030 Reset asserted mid-stream SHALL discard all in-flight words; first edge after clear_n rises SHALL behave as an empty pipeline.

Verification (WIDTH=8, CNT_W=16, out_ready=1 unless stated)
REQ-031 Accept 0x35 -> out 0xCA, class 1; 0x81 -> 0x02, class 2; 0x12 -> 0x12, class 0; back-to-back, outputs in order on consecutive cycles.
REQ-032 acc_en=1, words 0xFF, 0xFF, 0x81 -> outputs 0x08, 0x10, 0x12, class 3; then 0x40 acc_en=0 -> 0x40 class 0, acc stays 0x12.
REQ-033 Preload acc to 0xFC via ACCUM words, then 0xFF ACCUM -> output 0xFF (saturated), next 0x80 ACCUM -> 0xFF.
REQ-034 Stream 6 words, out_ready=0 for 5 cycles after first output -> in_ready=0 with S1/S2 full, cct_output frozen, all 6 delivered in order, word_count=6.
REQ-035 sync_clear pulse with 2 words in flight -> next cycle out_valid=0, word_count=0, acc=0; following word output normally.
REQ-036 clear_n pulsed low between edges mid-stream -> outputs zero immediately; after release, 0x35 yields 0xCA at nominal latency; word_count wraps 0xFFFF->0 when forced.
